// File: rtl/sat_engine_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sat_engine_ctrl_pkg
//  Description : Shared state encodings, result codes and types for the
//                SAT engine controller.
//  Revision    : 1.0  initial release
// ============================================================================
package sat_engine_ctrl_pkg;

    // State register encodings
    localparam logic [3:0] c_st_idle      = 4'd0;
    localparam logic [3:0] c_st_decide    = 4'd1;
    localparam logic [3:0] c_st_wait_dec  = 4'd2;
    localparam logic [3:0] c_st_imply     = 4'd3;
    localparam logic [3:0] c_st_analyze   = 4'd4;
    localparam logic [3:0] c_st_bkt_check = 4'd5;
    localparam logic [3:0] c_st_bkt       = 4'd6;
    localparam logic [3:0] c_st_wait_bkt  = 4'd7;
    localparam logic [3:0] c_st_done      = 4'd8;

    // Result codes reported alongside done_o
    localparam logic [1:0] c_res_timeout = 2'd0;
    localparam logic [1:0] c_res_sat     = 2'd1;
    localparam logic [1:0] c_res_bkt_out = 2'd2;
    localparam logic [1:0] c_res_unsat   = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE      = c_st_idle,
        ST_DECIDE    = c_st_decide,
        ST_WAIT_DEC  = c_st_wait_dec,
        ST_IMPLY     = c_st_imply,
        ST_ANALYZE   = c_st_analyze,
        ST_BKT_CHECK = c_st_bkt_check,
        ST_BKT       = c_st_bkt,
        ST_WAIT_BKT  = c_st_wait_bkt,
        ST_DONE      = c_st_done
    } state_t;

    typedef logic [1:0] result_t;

    // Width needed for a watchdog that must be able to reach max_val
    function automatic int wd_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : sat_engine_ctrl_pkg
`default_nettype wire

// File: rtl/sat_engine_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sat_engine_ctrl_if
//  Description : Handshake bundle between the SAT controller (master) and
//                the decision / BCP / analysis / backtrack datapath (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface sat_engine_ctrl_if #(
    parameter int WIDTH_LVL    = 16,
    parameter int WIDTH_BIN_ID = 10,
    parameter int WIDTH_CNT    = 16
);
    logic                    start_i;
    logic [WIDTH_BIN_ID-1:0] cur_bin_num_i;
    logic [WIDTH_LVL-1:0]    cur_lvl_i;
    logic                    start_decision_o;
    logic                    done_decision_i;
    logic                    decision_none_i;
    logic                    apply_imply_o;
    logic                    done_imply_i;
    logic                    find_conflict_i;
    logic                    apply_analyze_o;
    logic                    done_analyze_i;
    logic                    add_learntc_en_i;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_i;
    logic [WIDTH_LVL-1:0]    bkt_lvl_i;
    logic                    apply_bkt_cur_bin_o;
    logic                    done_bkt_cur_bin_i;
    logic                    busy_o;
    logic                    done_o;
    logic [1:0]              result_o;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_o;
    logic [WIDTH_LVL-1:0]    bkt_lvl_o;
    logic [WIDTH_CNT-1:0]    conflict_cnt_o;
    logic [WIDTH_CNT-1:0]    learnt_cnt_o;

    modport master (
        input  start_i, cur_bin_num_i, cur_lvl_i,
        input  done_decision_i, decision_none_i, done_imply_i, find_conflict_i,
        input  done_analyze_i, add_learntc_en_i, bkt_bin_i, bkt_lvl_i,
        input  done_bkt_cur_bin_i,
        output start_decision_o, apply_imply_o, apply_analyze_o,
        output apply_bkt_cur_bin_o, busy_o, done_o, result_o,
        output bkt_bin_o, bkt_lvl_o, conflict_cnt_o, learnt_cnt_o
    );

    modport slave (
        output start_i, cur_bin_num_i, cur_lvl_i,
        output done_decision_i, decision_none_i, done_imply_i, find_conflict_i,
        output done_analyze_i, add_learntc_en_i, bkt_bin_i, bkt_lvl_i,
        output done_bkt_cur_bin_i,
        input  start_decision_o, apply_imply_o, apply_analyze_o,
        input  apply_bkt_cur_bin_o, busy_o, done_o, result_o,
        input  bkt_bin_o, bkt_lvl_o, conflict_cnt_o, learnt_cnt_o
    );

endinterface : sat_engine_ctrl_if
`default_nettype wire

// File: rtl/sat_engine_ctrl_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter with synchronous clear.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr_i,
    input  wire logic             inc_i,
    output logic [WIDTH-1:0]      cnt_o
);

    logic [WIDTH-1:0] r_cnt;

    // Clear has priority over increment; count sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/sat_engine_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sat_engine_ctrl
//  Description : Top-level sequencer for one bin of a hardware SAT solver:
//                decide -> imply -> (analyze -> backtrack -> imply)* until
//                SAT, UNSAT, backtrack out of bin, or imply watchdog timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_engine_ctrl
    import sat_engine_ctrl_pkg::*;
#(
    parameter int WIDTH_LVL     = 16,
    parameter int WIDTH_BIN_ID  = 10,
    parameter int WIDTH_CNT     = 16,
    parameter int IMPLY_TIMEOUT = 255
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sat_engine_ctrl_if.master  bus
);

    localparam int c_wd_w = wd_width(IMPLY_TIMEOUT);
    localparam logic [c_wd_w-1:0] c_wd_max = c_wd_w'(IMPLY_TIMEOUT);

    state_t                  r_state;
    state_t                  w_state_next;
    result_t                 r_result;
    result_t                 w_result_next;
    logic                    w_result_load;
    logic                    w_conflict_inc;
    logic                    w_latch_bkt;
    logic                    w_cnt_clr;
    logic [c_wd_w-1:0]       r_wd;
    logic [WIDTH_BIN_ID-1:0] r_bkt_bin;
    logic [WIDTH_LVL-1:0]    r_bkt_lvl;

    // A start only counts when the engine is idle; it also restarts the statistics
    assign w_cnt_clr = (r_state == ST_IDLE) && bus.start_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus the side effects of each transition
    always_comb begin
        w_state_next   = r_state;
        w_result_load  = 1'b0;
        w_result_next  = r_result;
        w_conflict_inc = 1'b0;
        w_latch_bkt    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start_i) begin
                    w_state_next = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                w_state_next = ST_WAIT_DEC;
            end
            ST_WAIT_DEC: begin
                if (bus.done_decision_i) begin
                    if (bus.decision_none_i) begin
                        w_state_next  = ST_DONE;
                        w_result_load = 1'b1;
                        w_result_next = c_res_sat;
                    end else begin
                        w_state_next = ST_IMPLY;
                    end
                end
            end
            ST_IMPLY: begin
                // A conflict wins over a simultaneous BCP fixpoint
                if (bus.find_conflict_i) begin
                    w_conflict_inc = 1'b1;
                    if (bus.cur_lvl_i == '0) begin
                        w_state_next  = ST_DONE;
                        w_result_load = 1'b1;
                        w_result_next = c_res_unsat;
                    end else begin
                        w_state_next = ST_ANALYZE;
                    end
                end else if (bus.done_imply_i) begin
                    w_state_next = ST_DECIDE;
                end else if (r_wd == c_wd_max) begin
                    w_state_next  = ST_DONE;
                    w_result_load = 1'b1;
                    w_result_next = c_res_timeout;
                end
            end
            ST_ANALYZE: begin
                if (bus.done_analyze_i) begin
                    w_latch_bkt  = 1'b1;
                    w_state_next = ST_BKT_CHECK;
                end
            end
            ST_BKT_CHECK: begin
                // Backtracking into another bin is handed back to the caller
                if (r_bkt_bin == bus.cur_bin_num_i) begin
                    w_state_next = ST_BKT;
                end else begin
                    w_state_next  = ST_DONE;
                    w_result_load = 1'b1;
                    w_result_next = c_res_bkt_out;
                end
            end
            ST_BKT: begin
                w_state_next = ST_WAIT_BKT;
            end
            ST_WAIT_BKT: begin
                if (bus.done_bkt_cur_bin_i) begin
                    w_state_next = ST_IMPLY;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Imply watchdog: held at zero outside IMPLY so every entry starts fresh
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_IMPLY)) begin
            r_wd <= '0;
        end else if (r_wd != '1) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    // Result code and backtrack target registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result  <= c_res_timeout;
            r_bkt_bin <= '0;
            r_bkt_lvl <= '0;
        end else begin
            if (w_result_load) begin
                r_result <= w_result_next;
            end
            if (w_latch_bkt) begin
                r_bkt_bin <= bus.bkt_bin_i;
                r_bkt_lvl <= bus.bkt_lvl_i;
            end
        end
    end

    sat_counter #(
        .WIDTH (WIDTH_CNT)
    ) u_conflict_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (w_cnt_clr),
        .inc_i (w_conflict_inc),
        .cnt_o (bus.conflict_cnt_o)
    );

    sat_counter #(
        .WIDTH (WIDTH_CNT)
    ) u_learnt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (w_cnt_clr),
        .inc_i (bus.add_learntc_en_i),
        .cnt_o (bus.learnt_cnt_o)
    );

    // Strobes and levels decoded purely from the state register
    assign bus.start_decision_o    = (r_state == ST_DECIDE);
    assign bus.apply_imply_o       = (r_state == ST_IMPLY);
    assign bus.apply_analyze_o     = (r_state == ST_ANALYZE);
    assign bus.apply_bkt_cur_bin_o = (r_state == ST_BKT);
    assign bus.busy_o              = (r_state != ST_IDLE);
    assign bus.done_o              = (r_state == ST_DONE);
    assign bus.result_o            = r_result;
    assign bus.bkt_bin_o           = r_bkt_bin;
    assign bus.bkt_lvl_o           = r_bkt_lvl;

endmodule : sat_engine_ctrl
`default_nettype wire

// File: tb/tb_sat_engine_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sat_engine_ctrl
//  Description : Directed cycle-table bench for sat_engine_ctrl with a short
//                imply watchdog, plus timeout and mid-operation reset runs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sat_engine_ctrl;

    localparam int c_wl = 16;
    localparam int c_wb = 10;
    localparam int c_wc = 16;
    localparam int c_nv = 38;

    // Input control bits {rst,start,dd,dn,di,fc,da,db,al}
    localparam logic [8:0] I_RST = 9'h100;
    localparam logic [8:0] I_ST  = 9'h080;
    localparam logic [8:0] I_DD  = 9'h040;
    localparam logic [8:0] I_DN  = 9'h020;
    localparam logic [8:0] I_DI  = 9'h010;
    localparam logic [8:0] I_FC  = 9'h008;
    localparam logic [8:0] I_DA  = 9'h004;
    localparam logic [8:0] I_DB  = 9'h002;
    localparam logic [8:0] I_AL  = 9'h001;

    // Expected strobes {start_dec,apply_imply,apply_analyze,apply_bkt,busy,done}
    localparam logic [5:0] S_SD = 6'h20;
    localparam logic [5:0] S_AI = 6'h10;
    localparam logic [5:0] S_AA = 6'h08;
    localparam logic [5:0] S_AB = 6'h04;
    localparam logic [5:0] S_BZ = 6'h02;
    localparam logic [5:0] S_DN = 6'h01;

    typedef logic [65:0] obs_t;

    typedef struct {
        logic [8:0]      ctl;
        logic [c_wl-1:0] lvl;
        logic [c_wb-1:0] cbin;
        logic [c_wb-1:0] bbin;
        logic [c_wl-1:0] blvl;
        obs_t            exp;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    vec_t vecs [c_nv];

    sat_engine_ctrl_if #(.WIDTH_LVL(c_wl), .WIDTH_BIN_ID(c_wb), .WIDTH_CNT(c_wc)) bus ();

    sat_engine_ctrl #(
        .WIDTH_LVL     (c_wl),
        .WIDTH_BIN_ID  (c_wb),
        .WIDTH_CNT     (c_wc),
        .IMPLY_TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    function automatic vec_t mk(input logic [8:0] ctl, input logic [c_wl-1:0] lvl,
                                input logic [c_wb-1:0] cbin, input logic [c_wb-1:0] bbin,
                                input logic [c_wl-1:0] blvl, input logic [5:0] strb,
                                input logic [1:0] res, input logic [c_wb-1:0] ebin,
                                input logic [c_wl-1:0] elvl, input logic [c_wc-1:0] cc,
                                input logic [c_wc-1:0] lc);
        vec_t v;
        v.ctl  = ctl;
        v.lvl  = lvl;
        v.cbin = cbin;
        v.bbin = bbin;
        v.blvl = blvl;
        v.exp  = {strb, res, ebin, elvl, cc, lc};
        return v;
    endfunction

    function automatic obs_t observe();
        return {bus.start_decision_o, bus.apply_imply_o, bus.apply_analyze_o,
                bus.apply_bkt_cur_bin_o, bus.busy_o, bus.done_o, bus.result_o,
                bus.bkt_bin_o, bus.bkt_lvl_o, bus.conflict_cnt_o, bus.learnt_cnt_o};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait for the next active edge, drive the next inputs, then settle to the falling edge
    task automatic step(input logic [8:0] ctl, input logic [c_wl-1:0] lvl,
                        input logic [c_wb-1:0] cbin, input logic [c_wb-1:0] bbin,
                        input logic [c_wl-1:0] blvl);
        @(posedge clk);
        #1;
        rst                    = ctl[8];
        bus.start_i            = ctl[7];
        bus.done_decision_i    = ctl[6];
        bus.decision_none_i    = ctl[5];
        bus.done_imply_i       = ctl[4];
        bus.find_conflict_i    = ctl[3];
        bus.done_analyze_i     = ctl[2];
        bus.done_bkt_cur_bin_i = ctl[1];
        bus.add_learntc_en_i   = ctl[0];
        bus.cur_lvl_i          = lvl;
        bus.cur_bin_num_i      = cbin;
        bus.bkt_bin_i          = bbin;
        bus.bkt_lvl_i          = blvl;
        @(negedge clk);
    endtask

    initial begin
        int  n_imp;
        bit  got_done;
        n_checks = 0;
        n_errors = 0;

        // SAT on first decision, start ignored in DONE
        vecs[0]  = mk(9'h000, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0, 0);
        vecs[1]  = mk(I_ST,   0, 0, 0, 0, 6'h00, 0, 0, 0, 0, 0);
        vecs[2]  = mk(9'h000, 0, 0, 0, 0, S_SD | S_BZ, 0, 0, 0, 0, 0);
        vecs[3]  = mk(9'h000, 0, 0, 0, 0, S_BZ, 0, 0, 0, 0, 0);
        vecs[4]  = mk(I_DD | I_DN, 0, 0, 0, 0, S_BZ, 0, 0, 0, 0, 0);
        vecs[5]  = mk(I_ST,   0, 0, 0, 0, S_BZ | S_DN, 1, 0, 0, 0, 0);
        vecs[6]  = mk(9'h000, 0, 0, 0, 0, 6'h00, 1, 0, 0, 0, 0);
        // UNSAT: conflict at level 0 beats a simultaneous done_imply
        vecs[7]  = mk(I_ST,   0, 0, 0, 0, 6'h00, 1, 0, 0, 0, 0);
        vecs[8]  = mk(9'h000, 0, 0, 0, 0, S_SD | S_BZ, 1, 0, 0, 0, 0);
        vecs[9]  = mk(I_DD,   0, 0, 0, 0, S_BZ, 1, 0, 0, 0, 0);
        vecs[10] = mk(I_FC | I_DI, 0, 0, 0, 0, S_AI | S_BZ, 1, 0, 0, 0, 0);
        vecs[11] = mk(9'h000, 0, 0, 0, 0, S_BZ | S_DN, 3, 0, 0, 1, 0);
        vecs[12] = mk(9'h000, 0, 0, 0, 0, 6'h00, 3, 0, 0, 1, 0);
        // Conflict at level 3, backtrack within bin 5, re-imply, then SAT
        vecs[13] = mk(I_ST,   0, 0, 0, 0, 6'h00, 3, 0, 0, 1, 0);
        vecs[14] = mk(9'h000, 0, 0, 0, 0, S_SD | S_BZ, 3, 0, 0, 0, 0);
        vecs[15] = mk(I_DD,   0, 0, 0, 0, S_BZ, 3, 0, 0, 0, 0);
        vecs[16] = mk(I_DI | I_AL, 0, 0, 0, 0, S_AI | S_BZ, 3, 0, 0, 0, 0);
        vecs[17] = mk(9'h000, 0, 0, 0, 0, S_SD | S_BZ, 3, 0, 0, 0, 1);
        vecs[18] = mk(I_DD,   0, 0, 0, 0, S_BZ, 3, 0, 0, 0, 1);
        vecs[19] = mk(I_FC,   3, 5, 0, 0, S_AI | S_BZ, 3, 0, 0, 0, 1);
        vecs[20] = mk(I_DB,   3, 5, 5, 1, S_AA | S_BZ, 3, 0, 0, 1, 1);
        vecs[21] = mk(I_DA | I_AL, 3, 5, 5, 1, S_AA | S_BZ, 3, 0, 0, 1, 1);
        vecs[22] = mk(9'h000, 3, 5, 0, 0, S_BZ, 3, 5, 1, 1, 2);
        vecs[23] = mk(9'h000, 3, 5, 0, 0, S_AB | S_BZ, 3, 5, 1, 1, 2);
        vecs[24] = mk(I_ST,   3, 5, 0, 0, S_BZ, 3, 5, 1, 1, 2);
        vecs[25] = mk(I_DB,   3, 5, 0, 0, S_BZ, 3, 5, 1, 1, 2);
        vecs[26] = mk(I_DI,   3, 5, 0, 0, S_AI | S_BZ, 3, 5, 1, 1, 2);
        vecs[27] = mk(I_DD | I_DN, 3, 5, 0, 0, S_SD | S_BZ, 3, 5, 1, 1, 2);
        vecs[28] = mk(I_DD | I_DN, 3, 5, 0, 0, S_BZ, 3, 5, 1, 1, 2);
        vecs[29] = mk(9'h000, 3, 5, 0, 0, S_BZ | S_DN, 1, 5, 1, 1, 2);
        // Backtrack target in another bin -> BKT_OUT
        vecs[30] = mk(I_ST,   3, 5, 0, 0, 6'h00, 1, 5, 1, 1, 2);
        vecs[31] = mk(9'h000, 3, 5, 0, 0, S_SD | S_BZ, 1, 5, 1, 0, 0);
        vecs[32] = mk(I_DD,   3, 5, 0, 0, S_BZ, 1, 5, 1, 0, 0);
        vecs[33] = mk(I_FC,   3, 5, 0, 0, S_AI | S_BZ, 1, 5, 1, 0, 0);
        vecs[34] = mk(I_DA,   3, 5, 2, 1, S_AA | S_BZ, 1, 5, 1, 1, 0);
        vecs[35] = mk(9'h000, 3, 5, 0, 0, S_BZ, 1, 2, 1, 1, 0);
        vecs[36] = mk(9'h000, 3, 5, 0, 0, S_BZ | S_DN, 2, 2, 1, 1, 0);
        vecs[37] = mk(9'h000, 3, 5, 0, 0, 6'h00, 2, 2, 1, 1, 0);

        rst = 1'b1;
        bus.start_i = 1'b0;            bus.done_decision_i = 1'b0;
        bus.decision_none_i = 1'b0;    bus.done_imply_i = 1'b0;
        bus.find_conflict_i = 1'b0;    bus.done_analyze_i = 1'b0;
        bus.done_bkt_cur_bin_i = 1'b0; bus.add_learntc_en_i = 1'b0;
        bus.cur_lvl_i = '0;            bus.cur_bin_num_i = '0;
        bus.bkt_bin_i = '0;            bus.bkt_lvl_i = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < c_nv; i++) begin
            step(vecs[i].ctl, vecs[i].lvl, vecs[i].cbin, vecs[i].bbin, vecs[i].blvl);
            check($sformatf("row%0d", i), observe(), vecs[i].exp);
        end

        // Imply watchdog of 4: five IMPLY cycles, then TIMEOUT
        step(I_ST, 0, 0, 0, 0);
        step(9'h000, 0, 0, 0, 0);
        step(I_DD, 0, 0, 0, 0);
        n_imp    = 0;
        got_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(9'h000, 0, 0, 0, 0);
            if (bus.done_o) begin
                got_done = 1'b1;
                break;
            end
            if (bus.apply_imply_o) n_imp++;
        end
        check("timeout_done_seen", obs_t'(got_done), obs_t'(1));
        check("timeout_imply_cycles", obs_t'(n_imp), obs_t'(5));
        check("timeout_result", obs_t'(bus.result_o), obs_t'(0));

        // Reset while analysing: everything back to zero, no done pulse
        step(I_ST, 0, 0, 0, 0);
        step(9'h000, 0, 0, 0, 0);
        step(I_DD, 0, 0, 0, 0);
        step(I_FC | I_AL, 2, 0, 0, 0);
        step(9'h000, 2, 0, 0, 0);
        check("pre_reset_analyze", obs_t'({bus.apply_analyze_o, bus.conflict_cnt_o, bus.learnt_cnt_o}),
              obs_t'({1'b1, 16'd1, 16'd1}));
        step(I_RST, 2, 0, 0, 0);
        step(9'h000, 0, 0, 0, 0);
        check("post_reset_state", observe(), '0);
        for (int k = 0; k < 3; k++) begin
            step(9'h000, 0, 0, 0, 0);
            check($sformatf("post_reset_idle%0d", k), obs_t'({bus.busy_o, bus.done_o}), '0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sat_engine_ctrl
`default_nettype wire

// File: doc/sat_engine_ctrl.md
SAT_ENGINE_CTRL -- requirements
Module: sat_engine_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_LVL, default 16, level width.
REQ-002 SHALL have parameter WIDTH_BIN_ID, default 10, bin id width.
REQ-003 SHALL have parameter WIDTH_CNT, default 16, conflict counter width.
REQ-004 SHALL have parameter IMPLY_TIMEOUT, default 255, max cycles per imply phase.
REQ-005 SHALL have ports as follows; one clock; reset is synchronous and active-high:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 start_i  in  1  pulse; solve current bin
 cur_bin_num_i  in  WIDTH_BIN_ID  current bin id
 cur_lvl_i  in  WIDTH_LVL  current absolute level
 start_decision_o  out  1  one-cycle decision pulse
 done_decision_i  in  1  decision complete
 decision_none_i  in  1  valid with done_decision_i; no free variable
 apply_imply_o  out  1  level; BCP enable
 done_imply_i  in  1  BCP fixpoint reached
 find_conflict_i  in  1  conflict present
 apply_analyze_o  out  1  level; conflict analysis enable
 done_analyze_i  in  1  analysis complete
 add_learntc_en_i  in  1  learnt clause added
 bkt_bin_i  in  WIDTH_BIN_ID  backtrack bin
 bkt_lvl_i  in  WIDTH_LVL  backtrack level
 apply_bkt_cur_bin_o  out  1  one-cycle backtrack pulse
 done_bkt_cur_bin_i  in  1  backtrack complete
 busy_o  out  1  state != IDLE
 done_o  out  1  one-cycle completion pulse
 result_o  out  2  0 TIMEOUT, 1 SAT, 2 BKT_OUT, 3 UNSAT; valid with done_o
 bkt_bin_o  out  WIDTH_BIN_ID  latched backtrack bin
 bkt_lvl_o  out  WIDTH_LVL  latched backtrack level
 conflict_cnt_o  out  WIDTH_CNT  saturating conflict count
 learnt_cnt_o  out  WIDTH_CNT  saturating learnt clause count

Function
REQ-006 FSM states SHALL be IDLE, DECIDE, WAIT_DEC, IMPLY, ANALYZE, BKT_CHECK, BKT, WAIT_BKT, DONE.
REQ-007 IDLE: start_i -> DECIDE next cycle; start_i in any other state SHALL be ignored.
REQ-008 DECIDE: start_decision_o=1 exactly this cycle -> WAIT_DEC.
REQ-009 WAIT_DEC: done_decision_i&decision_none_i -> DONE, result SAT; done_decision_i&~decision_none_i -> IMPLY; else hold.
REQ-010 IMPLY: apply_imply_o=1; watchdog cleared on entry, increments each IMPLY cycle.
REQ-011 IMPLY, find_conflict_i=1 (priority over done_imply_i): conflict_cnt +1; cur_lvl_i==0 -> DONE, result UNSAT; else -> ANALYZE.
REQ-012 IMPLY, done_imply_i&~find_conflict_i -> DECIDE.
REQ-013 IMPLY, watchdog==IMPLY_TIMEOUT with neither event -> DONE, result TIMEOUT.
REQ-014 ANALYZE: apply_analyze_o=1; done_analyze_i -> latch bkt_bin_i/bkt_lvl_i into bkt_bin_o/bkt_lvl_o, -> BKT_CHECK.
REQ-015 add_learntc_en_i SHALL increment learnt_cnt in any state.
REQ-016 BKT_CHECK: bkt_bin_o==cur_bin_num_i -> BKT; else -> DONE, result BKT_OUT.
REQ-017 BKT: apply_bkt_cur_bin_o=1 exactly this cycle -> WAIT_BKT.
REQ-018 WAIT_BKT: done_bkt_cur_bin_i -> IMPLY (re-imply after backtrack).
REQ-019 DONE: done_o=1 and result_o valid exactly this cycle -> IDLE.
REQ-020 Strobes and levels SHALL be Moore-decoded from the state register; no combinational input-to-output path.
REQ-021 Counters SHALL saturate at all-ones; they clear on reset and on start_i accepted in IDLE.
REQ-022 done_* inputs arriving in states that do not wait for them SHALL be ignored.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, including mid-operation, with no done_o emitted.
REQ-024 Reset SHALL zero all outputs, counters, watchdog and latched bkt_bin_o/bkt_lvl_o; result_o resets to 0.

Structure
REQ-025 State encodings and result codes SHALL be constants in the shared sat_engine package.
REQ-026 The saturating counter SHALL be a sub-module sat_counter, instantiated twice (conflicts, learnt clauses).

Verification
REQ-027 start_i; done_decision_i with decision_none_i=1 two cycles later -> done_o=1, result_o=1 (SAT).
REQ-028 Decide, imply with find_conflict_i=1, cur_lvl_i=0 -> result_o=3 (UNSAT), conflict_cnt_o=1, apply_analyze_o never high.
REQ-029 Conflict at cur_lvl_i=3; done_analyze_i with bkt_bin_i=5, cur_bin_num_i=5, bkt_lvl_i=1 -> one-cycle apply_bkt_cur_bin_o, then done_bkt_cur_bin_i -> apply_imply_o=1.
REQ-030 Same with bkt_bin_i=2, cur_bin_num_i=5 -> result_o=2, bkt_bin_o=2, bkt_lvl_o=1, no apply_bkt_cur_bin_o.
REQ-031 IMPLY_TIMEOUT=4, hold done_imply_i/find_conflict_i low -> done_o with result_o=0 after 5th IMPLY cycle.
REQ-032 rst=1 during ANALYZE -> next cycle busy_o=0, apply_analyze_o=0, counters=0, no done_o.
